// File: rtl/axi_cmd_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_cmd_rr_arbiter
// Brief    : Round-robin arbiter feeding one registered AXI command slot,
//            with zero-length command drop reporting.
// Revision : 1.0 - initial release
// ============================================================================
module axi_cmd_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_WD = 32,
  localparam int ID_WD   = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*ADDR_WD-1:0] req_addr_i,
  input  logic [NUM_REQ*ADDR_WD-1:0] req_len_i,
  input  logic [NUM_REQ*2-1:0]     req_burst_i,
  input  logic [NUM_REQ*3-1:0]     req_size_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [ADDR_WD-1:0]       cmd_addr_o,
  output logic [ADDR_WD-1:0]       cmd_len_o,
  output logic [1:0]               cmd_burst_o,
  output logic [2:0]               cmd_size_o,
  output logic [ID_WD-1:0]         cmd_id_o,
  output logic                     drop_pulse_o,
  output logic [ID_WD-1:0]         drop_id_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } state_e;

  state_e             state_q;
  logic [ID_WD-1:0]   ptr_q;
  logic [ID_WD-1:0]   ptr_d;
  logic               cmd_valid_q;
  logic [ADDR_WD-1:0] cmd_addr_q;
  logic [ADDR_WD-1:0] cmd_len_q;
  logic [1:0]         cmd_burst_q;
  logic [2:0]         cmd_size_q;
  logic [ID_WD-1:0]   cmd_id_q;
  logic               drop_pulse_q;
  logic [ID_WD-1:0]   drop_id_q;

  logic               open_w;
  logic               win_found_w;
  logic [ID_WD-1:0]   win_idx_w;
  logic               accept_w;
  logic [ADDR_WD-1:0] win_addr_w;
  logic [ADDR_WD-1:0] win_len_w;
  logic [1:0]         win_burst_w;
  logic [2:0]         win_size_w;
  logic               win_zero_w;

  // Slot can take a new command when empty or when it is being drained this cycle.
  assign open_w = (state_q == S_IDLE) || cmd_ready_i;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    int unsigned idx;
    win_found_w = 1'b0;
    win_idx_w   = '0;
    idx         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req_valid_i[idx]) begin
        win_found_w = 1'b1;
        win_idx_w   = ID_WD'(idx);
      end
    end
  end

  assign accept_w = open_w && win_found_w;

  always_comb begin
    win_addr_w  = req_addr_i[int'(win_idx_w)*ADDR_WD +: ADDR_WD];
    win_len_w   = req_len_i[int'(win_idx_w)*ADDR_WD +: ADDR_WD];
    win_burst_w = req_burst_i[int'(win_idx_w)*2 +: 2];
    win_size_w  = req_size_i[int'(win_idx_w)*3 +: 3];
  end

  assign win_zero_w = (win_len_w == '0);

  assign ptr_d = (win_idx_w == ID_WD'(NUM_REQ - 1)) ? '0 : win_idx_w + ID_WD'(1);

  always_comb begin
    req_ready_o = '0;
    if (accept_w) begin
      req_ready_o[win_idx_w] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      cmd_burst_q  <= '0;
      cmd_size_q   <= '0;
      cmd_id_q     <= '0;
      drop_pulse_q <= 1'b0;
      drop_id_q    <= '0;
    end else begin
      drop_pulse_q <= 1'b0;
      if (accept_w) begin
        ptr_q <= ptr_d;
      end
      case (state_q)
        S_IDLE: begin
          if (accept_w && !win_zero_w) begin
            state_q     <= S_FULL;
            cmd_valid_q <= 1'b1;
            cmd_addr_q  <= win_addr_w;
            cmd_len_q   <= win_len_w;
            cmd_burst_q <= win_burst_w;
            cmd_size_q  <= win_size_w;
            cmd_id_q    <= win_idx_w;
          end else if (accept_w) begin
            drop_pulse_q <= 1'b1;
            drop_id_q    <= win_idx_w;
          end
        end
        S_FULL: begin
          // Holding while cmd_ready_i is low keeps the slot stable for the master.
          if (cmd_ready_i) begin
            if (accept_w && !win_zero_w) begin
              cmd_addr_q  <= win_addr_w;
              cmd_len_q   <= win_len_w;
              cmd_burst_q <= win_burst_w;
              cmd_size_q  <= win_size_w;
              cmd_id_q    <= win_idx_w;
            end else begin
              state_q     <= S_IDLE;
              cmd_valid_q <= 1'b0;
              if (accept_w) begin
                drop_pulse_q <= 1'b1;
                drop_id_q    <= win_idx_w;
              end
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_valid_o  = cmd_valid_q;
  assign cmd_addr_o   = cmd_addr_q;
  assign cmd_len_o    = cmd_len_q;
  assign cmd_burst_o  = cmd_burst_q;
  assign cmd_size_o   = cmd_size_q;
  assign cmd_id_o     = cmd_id_q;
  assign drop_pulse_o = drop_pulse_q;
  assign drop_id_o    = drop_id_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_cmd_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_cmd_rr_arbiter
// Brief    : Directed bench with a reference-model scoreboard for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_cmd_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*AW-1:0] req_len;
  logic [N*2-1:0]  req_burst;
  logic [N*3-1:0]  req_size;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [AW-1:0]   cmd_len;
  logic [1:0]      cmd_burst;
  logic [2:0]      cmd_size;
  logic [1:0]      cmd_id;
  logic            drop_pulse;
  logic [1:0]      drop_id;

  axi_cmd_rr_arbiter #(.NUM_REQ(N), .ADDR_WD(AW)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .req_burst_i(req_burst), .req_size_i(req_size),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .cmd_addr_o(cmd_addr), .cmd_len_o(cmd_len),
    .cmd_burst_o(cmd_burst), .cmd_size_o(cmd_size),
    .cmd_id_o(cmd_id), .drop_pulse_o(drop_pulse), .drop_id_o(drop_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    logic [1:0]    burst;
    logic [2:0]    size;
    logic [1:0]    id;
  } cmd_t;

  cmd_t sb[$];
  int   m_ptr = 0;
  logic m_full = 1'b0;
  logic m_drop = 1'b0;
  int   m_drop_id = 0;

  // Reference model evaluated mid-cycle; it predicts what the next rising edge does.
  always @(negedge clk) begin
    cmd_t       cur;
    logic       found;
    int         w;
    logic       open;
    logic       nf;
    logic [N-1:0] exp_rdy;
    if (reset) begin
      m_ptr  = 0;
      m_full = 1'b0;
      m_drop = 1'b0;
      sb.delete();
    end else begin
      check("mon_cmd_valid", cmd_valid, m_full);
      if (m_full) begin
        if (sb.size() == 0) check("mon_sb_empty", 0, 1);
        else begin
          cur = sb[0];
          check("mon_cmd_addr", cmd_addr, cur.addr);
          check("mon_cmd_len", cmd_len, cur.len);
          check("mon_cmd_burst", cmd_burst, cur.burst);
          check("mon_cmd_size", cmd_size, cur.size);
          check("mon_cmd_id", cmd_id, cur.id);
        end
      end
      check("mon_drop_pulse", drop_pulse, m_drop);
      if (m_drop) check("mon_drop_id", drop_id, m_drop_id);
      found = 1'b0;
      w = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_ptr + k) % N]) begin
          found = 1'b1;
          w = (m_ptr + k) % N;
        end
      end
      open    = !m_full || cmd_ready;
      exp_rdy = '0;
      if (open && found) exp_rdy[w] = 1'b1;
      check("mon_req_ready", req_ready, exp_rdy);
      nf = m_full && !cmd_ready;
      if (m_full && cmd_ready && sb.size() > 0) void'(sb.pop_front());
      m_drop = 1'b0;
      if (open && found) begin
        m_ptr = (w + 1) % N;
        if (req_len[w*AW +: AW] != 0) begin
          cur.addr  = req_addr[w*AW +: AW];
          cur.len   = req_len[w*AW +: AW];
          cur.burst = req_burst[w*2 +: 2];
          cur.size  = req_size[w*3 +: 3];
          cur.id    = 2'(w);
          sb.push_back(cur);
          nf = 1'b1;
        end else begin
          m_drop    = 1'b1;
          m_drop_id = w;
        end
      end
      m_full = nf;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [AW-1:0] l, input logic [1:0] b, input logic [2:0] s);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_len[i*AW +: AW]   = l;
    req_burst[i*2 +: 2]   = b;
    req_size[i*3 +: 3]    = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    req_burst = '0;
    req_size  = '0;
    cmd_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_cmd_id", cmd_id, 0);
    check("rst_drop_pulse", drop_pulse, 0);
    check("rst_req_ready", req_ready, 0);

    // Single requester, one-cycle latency into the slot.
    set_req(0, 1'b1, 32'h8, 32'h100, 2'd1, 3'd2);
    #1;
    check("t1_req_ready", req_ready, 4'b0001);
    tick();
    set_req(0, 1'b0, 32'h8, 32'h100, 2'd1, 3'd2);
    check("t1_cmd_valid", cmd_valid, 1);
    check("t1_cmd_addr", cmd_addr, 32'h8);
    check("t1_cmd_len", cmd_len, 32'h100);
    check("t1_cmd_id", cmd_id, 0);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("t1_drained", cmd_valid, 0);

    // All requesters busy, master always ready: back-to-back rotation from ptr=1.
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 32'h1000 * (i + 1), 32'h40 + i, 2'(i), 3'(i + 1));
    cmd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t2_cmd_valid", cmd_valid, 1);
      check("t2_cmd_id", cmd_id, (1 + k) % N);
    end

    // Backpressure: slot frozen, no grants.
    cmd_ready = 1'b0;
    #1;
    check("t3_req_ready_hold", req_ready, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3_hold_id", cmd_id, 0);
      check("t3_hold_addr", cmd_addr, 32'h1000);
      check("t3_hold_valid", cmd_valid, 1);
      check("t3_hold_rdy", req_ready, 0);
    end
    cmd_ready = 1'b1;
    #1;
    check("t3_release_rdy", req_ready, 4'b0010);
    tick();
    check("t3_reload_id", cmd_id, 1);
    check("t3_reload_valid", cmd_valid, 1);
    req_valid = '0;
    tick();
    check("t3_idle", cmd_valid, 0);

    // Zero-length command at ptr=2 is dropped and reported.
    cmd_ready = 1'b0;
    set_req(2, 1'b1, 32'hABC0, 32'h0, 2'd2, 3'd3);
    #1;
    check("t4_req_ready", req_ready, 4'b0100);
    tick();
    set_req(2, 1'b0, 32'hABC0, 32'h0, 2'd2, 3'd3);
    check("t4_no_valid", cmd_valid, 0);
    check("t4_drop_pulse", drop_pulse, 1);
    check("t4_drop_id", drop_id, 2);
    tick();
    check("t4_drop_clear", drop_pulse, 0);

    // req1 and req3 with ptr=3: req3 first, then req1.
    cmd_ready = 1'b1;
    set_req(1, 1'b1, 32'h5100, 32'h11, 2'd1, 3'd1);
    set_req(3, 1'b1, 32'h5300, 32'h33, 2'd3, 3'd3);
    #1;
    check("t5_first_rdy", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    check("t5_first_id", cmd_id, 3);
    #1;
    check("t5_second_rdy", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    check("t5_second_id", cmd_id, 1);
    tick();
    check("t5_idle", cmd_valid, 0);
    set_req(1, 1'b1, 32'h5100, 32'h11, 2'd1, 3'd1);
    set_req(2, 1'b1, 32'h5200, 32'h22, 2'd2, 3'd2);
    #1;
    check("t5_ptr_is_2", req_ready, 4'b0100);
    req_valid = '0;

    // Reset while the slot holds requester 3's command.
    cmd_ready = 1'b0;
    set_req(3, 1'b1, 32'h7300, 32'h77, 2'd1, 3'd4);
    tick();
    req_valid[3] = 1'b0;
    check("t6_pre_valid", cmd_valid, 1);
    check("t6_pre_id", cmd_id, 3);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", cmd_valid, 0);
    check("t6_async_id", cmd_id, 0);
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 32'h7000, 32'h70, 2'd0, 3'd0);
    set_req(3, 1'b1, 32'h7300, 32'h77, 2'd1, 3'd4);
    #1;
    check("t6_ptr0_rdy", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    check("t6_winner_id", cmd_id, 0);
    check("t6_winner_addr", cmd_addr, 32'h7000);
    req_valid = '0;
    cmd_ready = 1'b1;
    tick();
    tick();
    check("end_idle", cmd_valid, 0);
    check("end_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
